// File: rtl/fp_pkg.sv
// Shared single-precision constants and types for the adder's alignment
// and normalization stages.
package fp_pkg;

    localparam int unsigned EXP_N      = 8;
    localparam int unsigned FRAC_N     = 23;
    localparam int unsigned MANTISSA_N = 25;
    localparam int unsigned MAX_SHIFT  = MANTISSA_N + 1;

    typedef struct packed {
        logic              sign;
        logic [EXP_N-1:0]  exp;
        logic [FRAC_N-1:0] frac;
    } fp_t;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        DONE
    } state_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational unpack of one operand into sign, effective exponent,
// headroom-padded mantissa and an Inf/NaN flag.
module fp_unpack
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W  = fp_pkg::EXP_N,
    parameter int unsigned FRAC_W = fp_pkg::FRAC_N,
    parameter int unsigned MANT_W = fp_pkg::MANTISSA_N
) (
    input  logic [EXP_W+FRAC_W:0] op_i,
    output logic                  sign_o,
    output logic [EXP_W-1:0]      exp_o,
    output logic [MANT_W-1:0]     mant_o,
    output logic                  special_o
);

    logic [EXP_W-1:0]  raw_exp;
    logic [FRAC_W-1:0] frac;
    logic              hidden;

    assign sign_o  = op_i[EXP_W+FRAC_W];
    assign raw_exp = op_i[EXP_W+FRAC_W-1:FRAC_W];
    assign frac    = op_i[FRAC_W-1:0];
    assign hidden  = |raw_exp;

    // Denormals use effective exponent 1 with no hidden bit.
    assign exp_o     = hidden ? raw_exp : EXP_W'(1);
    assign mant_o    = MANT_W'({1'b0, hidden, frac});
    assign special_o = &raw_exp;

endmodule

// File: rtl/operand_aligner.sv
// Pre-add alignment: orders two operands by magnitude and right-shifts the
// smaller mantissa one bit per cycle, accumulating a sticky bit.
module operand_aligner #(
    parameter int unsigned EXP_N      = fp_pkg::EXP_N,
    parameter int unsigned FRAC_N     = fp_pkg::FRAC_N,
    parameter int unsigned MANTISSA_N = fp_pkg::MANTISSA_N,
    parameter int unsigned MAX_SHIFT  = MANTISSA_N + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [EXP_N+FRAC_N:0]   opA,
    input  logic [EXP_N+FRAC_N:0]   opB,
    input  logic                    inValid,
    output logic                    inReady,
    output logic                    outValid,
    input  logic                    outReady,
    output logic                    bigSign,
    output logic [MANTISSA_N-1:0]   bigMantissa,
    output logic                    smallSign,
    output logic [MANTISSA_N-1:0]   smallMantissa,
    output logic                    sticky,
    output logic [EXP_N-1:0]        exp,
    output logic                    swapped,
    output logic                    special
);

    import fp_pkg::*;

    localparam int unsigned CNT_W = $clog2(MAX_SHIFT + 1);

    logic                  sign_a, sign_b, spec_a, spec_b;
    logic [EXP_N-1:0]      exp_a, exp_b;
    logic [MANTISSA_N-1:0] mant_a, mant_b;

    fp_unpack #(.EXP_W(EXP_N), .FRAC_W(FRAC_N), .MANT_W(MANTISSA_N)) u_unpack_a (
        .op_i      (opA),
        .sign_o    (sign_a),
        .exp_o     (exp_a),
        .mant_o    (mant_a),
        .special_o (spec_a)
    );

    fp_unpack #(.EXP_W(EXP_N), .FRAC_W(FRAC_N), .MANT_W(MANTISSA_N)) u_unpack_b (
        .op_i      (opB),
        .sign_o    (sign_b),
        .exp_o     (exp_b),
        .mant_o    (mant_b),
        .special_o (spec_b)
    );

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  big_sign_q, big_sign_d;
    logic [MANTISSA_N-1:0] big_mant_q, big_mant_d;
    logic                  small_sign_q, small_sign_d;
    logic [MANTISSA_N-1:0] small_mant_q, small_mant_d;
    logic                  sticky_q, sticky_d;
    logic [EXP_N-1:0]      exp_q, exp_d;
    logic                  swapped_q, swapped_d;
    logic                  special_q, special_d;

    logic                  a_big;
    logic                  any_special;
    logic [EXP_N-1:0]      diff;
    logic [CNT_W-1:0]      count;

    // Full tie (equal exponent and mantissa) keeps A as the big operand.
    assign a_big       = (exp_a > exp_b) || ((exp_a == exp_b) && (mant_a >= mant_b));
    assign any_special = spec_a | spec_b;
    assign diff        = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
    assign count       = (32'(diff) > MAX_SHIFT) ? CNT_W'(MAX_SHIFT) : CNT_W'(diff);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        big_sign_d   = big_sign_q;
        big_mant_d   = big_mant_q;
        small_sign_d = small_sign_q;
        small_mant_d = small_mant_q;
        sticky_d     = sticky_q;
        exp_d        = exp_q;
        swapped_d    = swapped_q;
        special_d    = special_q;

        unique case (state_q)
            IDLE: begin
                if (inValid) begin
                    big_sign_d   = a_big ? sign_a : sign_b;
                    big_mant_d   = a_big ? mant_a : mant_b;
                    small_sign_d = a_big ? sign_b : sign_a;
                    small_mant_d = a_big ? mant_b : mant_a;
                    exp_d        = a_big ? exp_a : exp_b;
                    swapped_d    = ~a_big;
                    special_d    = any_special;
                    sticky_d     = 1'b0;
                    if (any_special || (count == '0)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = count;
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                small_mant_d = small_mant_q >> 1;
                sticky_d     = sticky_q | small_mant_q[0];
                cnt_d        = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (outReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            big_sign_q   <= 1'b0;
            big_mant_q   <= '0;
            small_sign_q <= 1'b0;
            small_mant_q <= '0;
            sticky_q     <= 1'b0;
            exp_q        <= '0;
            swapped_q    <= 1'b0;
            special_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            big_sign_q   <= big_sign_d;
            big_mant_q   <= big_mant_d;
            small_sign_q <= small_sign_d;
            small_mant_q <= small_mant_d;
            sticky_q     <= sticky_d;
            exp_q        <= exp_d;
            swapped_q    <= swapped_d;
            special_q    <= special_d;
        end
    end

    assign inReady       = (state_q == IDLE);
    assign outValid      = (state_q == DONE);
    assign bigSign       = big_sign_q;
    assign bigMantissa   = big_mant_q;
    assign smallSign     = small_sign_q;
    assign smallMantissa = small_mant_q;
    assign sticky        = sticky_q;
    assign exp           = exp_q;
    assign swapped       = swapped_q;
    assign special       = special_q;

endmodule

// File: doc/operand_aligner.md
# operand_aligner

Pre-add alignment stage of the floating-point adder, the inverse of post-add normalization. It accepts two IEEE-754 single-precision operands and unpacks them, then orders them by magnitude. The smaller operand's mantissa is right-shifted one bit per cycle until its exponent matches the larger operand's, with a sticky bit accumulated along the way. The aligned pair feeds the mantissa adder; the adder's 25-bit result goes to the normalizer with the common exponent.

## Interface
Parameters:
- EXP_N, 8, exponent width
- FRAC_N, 23, stored fraction width
- MANTISSA_N, 25, aligned mantissa width: {1'b0 headroom, hidden bit, fraction}
- MAX_SHIFT, MANTISSA_N+1 (26), shift clamp; any larger difference gives an identical result

Ports (clock and reset as the rest of the design):
- clock, in, 1, single clock; all state updates on the rising edge
- reset, in, 1, synchronous, active-high
- opA, in, 1+EXP_N+FRAC_N, operand A as {sign, exp, frac}
- opB, in, 1+EXP_N+FRAC_N, operand B
- inValid, in, 1, operands present
- inReady, out, 1, block can accept operands
- outValid, out, 1, aligned result present
- outReady, in, 1, downstream consumes the result
- bigSign, out, 1, sign of the larger-magnitude operand
- bigMantissa, out, MANTISSA_N, mantissa of the larger operand (unshifted)
- smallSign, out, 1, sign of the smaller operand
- smallMantissa, out, MANTISSA_N, mantissa of the smaller operand after right shift
- sticky, out, 1, OR of every bit shifted out of smallMantissa
- exp, out, EXP_N, common exponent (the larger operand's effective exponent)
- swapped, out, 1, 1 when B was the larger operand
- special, out, 1, either operand had exp == all-ones (Inf/NaN); mantissas are passed unshifted

## Operation
- Unpack each operand:
  - exp != 0: mantissa = {0, 1, frac}, effective exp = exp.
  - exp == 0: mantissa = {0, 0, frac}, effective exp = 1.
- Ordering:
  - big = operand with the larger effective exp.
  - Equal exps: big = operand with the larger mantissa.
  - Full tie: A is big and swapped = 0.
- d = effective exp difference (unsigned); count = min(d, MAX_SHIFT).
- State machine:
  - IDLE: inReady = 1. On inValid, latch the ordered operands, exp and swapped; clear sticky.
    - Go to DONE if special or count == 0.
    - Otherwise go to ALIGN with counter = count.
  - ALIGN: each cycle, smallMantissa <= smallMantissa >> 1, sticky <= sticky | smallMantissa[0], counter decrements. Go to DONE on the edge where the counter goes 1→0.
  - DONE: outValid = 1. On outReady, return to IDLE.
- inReady = 1 only in IDLE; outValid = 1 only in DONE; no overlap, so there is no simultaneous accept/deliver.
- Output registers hold their values while in DONE.

## Timing
- Reset values: state IDLE; all outputs 0 except inReady = 1.
- Accept on edge t (inValid && inReady): outValid rises in cycle t+1+count, where count is 0 for special operands.
- Latency is 1 cycle minimum and 27 cycles maximum (d ≥ 26).
- Back-to-back: next accept no earlier than the cycle after the outReady handshake edge.
- Output bits are stable from outValid rise until the handshake.
- inValid while busy is ignored; the upstream must hold its operands until it sees inReady.
- Reset asserted in any state: the next edge forces reset values and the in-flight operation is discarded.

## Structure
- Package fp_pkg holds:
  - EXP_N, FRAC_N and MANTISSA_N constants
  - packed struct for {sign, exp, frac}
  - state enum {IDLE, ALIGN, DONE}
- The normalizer shares this package.
- Natural sub-module: fp_unpack (combinational; operand → sign, effective exp, mantissa, special). It is instantiated twice.
- Compare/swap and the FSM sit in the top module.

## Test plan
- A=B=0x3F800000 (1.0): outValid in cycle t+1; big = small = 0x0800000, exp 0x7F, sticky 0, swapped 0.
- A=0x3F000000 (0.5), B=0x3F800000: swapped 1; small = 0x0400000 after 1 ALIGN cycle; outValid at t+2; exp 0x7F.
- A=0x4B800000, B=0x3F800001: d = 24; outValid at t+25; smallMantissa 0; sticky 1; exp 0x97.
- A=0x7E800000, B=0x00000001 (denormal): d clamps to 26; outValid at t+27; small 0; sticky 1.
- outReady held low for 5 cycles in DONE: outputs are bit-stable, inReady 0, and new inValid is ignored. Then outReady pulses, and IDLE follows one cycle later.
- Reset at the 3rd ALIGN cycle of a d = 10 operation: next cycle inReady 1, outValid 0, outputs 0. A fresh 1.0/1.0 then completes normally. Also A=0x7F800000 (Inf): special 1, outValid at t+1.
